serial_shifter: RTL
===================

SERIAL_SHIFTER -- requirements
Module: serial_shifter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock, all state changes on this edge except reset; rst  input  1  asynchronous active-high reset.
REQ-002 The block SHALL provide start  input  1  request pulse, sampled only in IDLE.
REQ-003 The block SHALL provide op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 SRA.
REQ-004 The block SHALL provide sa_src  input  32  shift-amount source (register value or zero-extended sa field); only bits [4:0] are used.
REQ-005 The block SHALL provide data  input  32  operand to be shifted.
REQ-006 The block SHALL provide result  output  32  shifted value, held until the next accepted start.
REQ-007 The block SHALL provide busy  output  1  high whenever state is not IDLE.
REQ-008 The block SHALL provide done  output  1  single-cycle pulse marking result valid.

Function
REQ-009 The block SHALL implement states IDLE, SHIFT and DONE, held in registers.
REQ-010 In IDLE with start=1, the block SHALL on the next edge load result<=data, op_r<=op and cnt<=sa_src[4:0], where cnt is a 5-bit register.
REQ-011 On that edge the block SHALL go to DONE if sa_src[4:0]=0 and to SHIFT otherwise.
REQ-012 The block SHALL ignore sa_src[31:5] entirely; any value there SHALL NOT change the result.
REQ-013 In SHIFT, each edge SHALL shift result by exactly one bit and decrement cnt by 1.
REQ-014 The one-bit shift SHALL be: SLL {result[30:0],0}; SRL {0,result[31:1]}; SRA {result[31],result[31:1]}.
REQ-015 In SHIFT, the edge on which cnt=1 SHALL perform the final shift and move the state to DONE.
REQ-016 cnt SHALL never wrap: no shift or decrement SHALL occur when cnt=0.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE on the next edge.
REQ-018 Latency: if start is high in cycle 0 (IDLE), done SHALL be high in cycle sa_src[4:0]+1. This gives cycle 1 for an amount of 0 and cycle 32 for an amount of 31.
REQ-019 start SHALL be ignored in SHIFT and DONE, with no queuing.
REQ-020 A start in the cycle after done (IDLE) SHALL be accepted normally, so the back-to-back period is N+2 cycles.
REQ-021 Operands SHALL be captured at the start edge; data, op and sa_src changes while busy=1 SHALL NOT affect the result.
REQ-022 result SHALL hold its value in IDLE, including after done, until the next accepted start.
REQ-023 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-024 done and busy SHALL be driven directly from the state register (glitch-free outputs).

Reset
REQ-025 While rst=1, independent of clk, the block SHALL force state=IDLE, result=32'h0, cnt=0, op_r=00, busy=0 and done=0.
REQ-026 Reset asserted during SHIFT or DONE SHALL abort the operation immediately, with no done pulse.
REQ-027 After rst falls, the first start SHALL be accepted on the first rising edge.

Verification
REQ-028 SLL scenario: data=32'h0000_0001, sa_src=32'h0000_0004, op=00 -> done in cycle 5, result=32'h0000_0010, busy high cycles 1-5.
REQ-029 Zero and ignored-upper-bits scenario: data=32'hDEAD_BEEF, sa_src=32'hFFFF_FFE0 (low 5 bits 0), op=01 -> done in cycle 1, result=32'hDEAD_BEEF.
REQ-030 SRA maximum scenario: data=32'h8000_0000, sa_src=31, op=10 -> done in cycle 32, result=32'hFFFF_FFFF; same with op=01 -> 32'h0000_0001.
REQ-031 Busy-ignore scenario: start with sa=8, then pulse start with different operands in cycles 2 and 8 -> exactly one done, in cycle 9, with the original result.
REQ-032 Reset-mid-op scenario: start with sa=20, assert rst in cycle 7 between edges -> outputs zero immediately, no done; a new start with sa=3 after release -> done 4 cycles later.
REQ-033 Back-to-back scenario: second start in the cycle after done -> accepted, first result held until that start edge.

Source files
------------

// File: rtl/serial_shifter.sv
// Multi-cycle barrel-free shifter: one bit per clock, amount taken from sa_src[4:0].
// Operands are captured on the accepted start; result holds until the next start.
module serial_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] sa_src,
    input  logic [31:0] data,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    // state | meaning
    // IDLE  | waiting for start, result held
    // SHIFT | one-bit shift per edge while cnt counts down to zero
    // DONE  | result valid for one cycle
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic [1:0]  op_r, op_nxt;
    logic [31:0] result_nxt;
    logic [31:0] shifted;

    // Only the low five bits carry the amount; the rest is deliberately dropped.
    logic unused_sa_hi;
    assign unused_sa_hi = ^sa_src[31:5];

    always_comb begin
        case (op_r)
            2'b00:   shifted = {result[30:0], 1'b0};
            2'b01:   shifted = {1'b0, result[31:1]};
            default: shifted = {result[31], result[31:1]};
        endcase
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        op_nxt     = op_r;
        result_nxt = result;
        case (state)
            IDLE: begin
                if (start) begin
                    result_nxt = data;
                    op_nxt     = op;
                    cnt_nxt    = sa_src[4:0];
                    state_nxt  = (sa_src[4:0] == 5'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != 5'd0) begin
                    result_nxt = shifted;
                    cnt_nxt    = cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state_nxt = DONE;
                    end
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            op_r   <= 2'b00;
            result <= 32'h0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            op_r   <= op_nxt;
            result <= result_nxt;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
